// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, registered sync/blank/coordinate outputs.
// Define VGA_POS_SYNC_EN for active-high hs/vs (default build: active-low).
module vga_sync_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic       hs,
    output logic       vs,
    output logic       video_on,
    output logic [9:0] px_x,
    output logic [9:0] px_y,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
            $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_chk
            $error("vga_sync_gen: CLK_DIV must be in 1..16");
        end
    endgenerate

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

`ifdef VGA_POS_SYNC_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif

    logic [3:0] div_q, div_d;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       tick;
    logic       hs_q, vs_q, von_q, pix_en_q, fs_q;
    logic [9:0] x_q, y_q;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 4'd1;
        h_d   = (h_q == H_LAST) ? '0 : h_q + 10'd1;
        v_d   = v_q;
        if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
    end

    // Decodes use the next counter values so every output changes on the tick edge together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q    <= '0;
            h_q      <= H_LAST;
            v_q      <= V_LAST;
            hs_q     <= ~SYNC_ON;
            vs_q     <= ~SYNC_ON;
            von_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            pix_en_q <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= tick;
            fs_q     <= tick && (h_d == '0) && (v_d == '0);
            if (tick) begin
                h_q   <= h_d;
                v_q   <= v_d;
                x_q   <= h_d;
                y_q   <= v_d;
                von_q <= (h_d < H_VIS) && (v_d < V_VIS);
                hs_q  <= ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? SYNC_ON : ~SYNC_ON;
                vs_q  <= ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? SYNC_ON : ~SYNC_ON;
            end
        end
    end

    assign pix_en      = pix_en_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign video_on    = von_q;
    assign px_x        = x_q;
    assign px_y        = y_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a reduced raster (30x19 totals, CLK_DIV=4).
module tb_vga_sync_gen;

    localparam int CD = 4;
    localparam int HT = 30;          // 16 + 4 + 6 + 4
    localparam int VT = 19;          // 12 + 2 + 2 + 3
    localparam int HA = 16;
    localparam int VA = 12;
    localparam int HS_LO = 20;
    localparam int HS_HI = 25;
    localparam int VS_LO = 14;
    localparam int VS_HI = 15;
    localparam int FRAME_CLKS = 2280; // 30*19*4
    localparam int RX = 10;
    localparam int RY = 5;
    localparam int P1 = HT * VT + RY * HT + RX + 1;
    localparam int P2 = 2 * HT + 3;

`ifdef VGA_POS_SYNC_EN
    localparam logic ON = 1'b1;
`else
    localparam logic ON = 1'b0;
`endif

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fs;
    } exp_t;

    localparam exp_t RST = '{x: 10'd0, y: 10'd0, hs: ~ON, vs: ~ON, von: 1'b0, fs: 1'b0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_en, hs, vs, video_on, frame_start;
    logic [9:0] px_x, px_y;

    exp_t q[$];
    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .CLK_DIV(CD),
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pix_en(pix_en),
        .hs(hs),
        .vs(vs),
        .video_on(video_on),
        .px_x(px_x),
        .px_y(px_y),
        .frame_start(frame_start)
    );

    function automatic exp_t model(int k);
        exp_t e;
        int x, y;
        x = k % HT;
        y = (k / HT) % VT;
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.hs  = (x >= HS_LO && x <= HS_HI) ? ON : ~ON;
        e.vs  = (y >= VS_LO && y <= VS_HI) ? ON : ~ON;
        e.von = (x < HA) && (y < VA);
        e.fs  = (x == 0) && (y == 0);
        return e;
    endfunction

    task automatic check(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got %0d exp %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic exp_t sample();
        exp_t s;
        s = '{x: px_x, y: px_y, hs: hs, vs: vs, von: video_on, fs: frame_start};
        return s;
    endfunction

    task automatic check_reset(string tag);
        check({tag, ".pix_en"}, int'(pix_en), 0);
        check({tag, ".outs"}, int'(sample()), int'(RST));
    endtask

    task automatic wait_drain(int limit);
        int n = 0;
        while (q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_timeout", int'(q.size()), 0);
        q.delete();
    endtask

    // Monitor: pops one expectation per pix_en, checks tick spacing, frame period and hold between ticks.
    initial begin
        int gap = 0;
        longint cyc = 0;
        longint last_fs = -1;
        exp_t last = RST;
        exp_t e, held;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                gap = 0;
                last = RST;
                last_fs = -1;
            end else begin
                gap++;
            end
            @(negedge clk);
            if (pix_en) begin
                check("tick_gap", gap, CD);
                gap = 0;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_tick got x=%0d y=%0d exp no tick", px_x, px_y);
                end else begin
                    e = q.pop_front();
                    check("px_x", int'(px_x), int'(e.x));
                    check("px_y", int'(px_y), int'(e.y));
                    check("hs", int'(hs), int'(e.hs));
                    check("vs", int'(vs), int'(e.vs));
                    check("video_on", int'(video_on), int'(e.von));
                    check("frame_start", int'(frame_start), int'(e.fs));
                    last = e;
                end
                if (frame_start) begin
                    if (last_fs >= 0) check("frame_period", int'(cyc - last_fs), FRAME_CLKS);
                    last_fs = cyc;
                end
            end else begin
                held = last;
                held.fs = 1'b0;
                check("hold", int'(sample()), int'(held));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_reset("por");
        end
        for (int k = 0; k < P1; k++) q.push_back(model(k));
        rst_n = 1'b1;
        wait_drain(P1 * CD + 20);

        check("pre_rst_x", int'(px_x), RX);
        check("pre_rst_y", int'(px_y), RY);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset("mid_rst");
        for (int k = 0; k < P2; k++) q.push_back(model(k));
        rst_n = 1'b1;
        wait_drain(P2 * CD + 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator for the snake VGA path; runs from the 100 MHz board clock with an internal pixel-rate enable.
- Produces HS/VS, a blanking flag and the current pixel coordinates.
- The downstream colour/render stage consumes these to drive R/G/B and the VGA connector.
- Replaces the free-running counter pair in the top level with one self-consistent timing block.

Parameters:
- CLK_DIV, 4, clk cycles per pixel (100 MHz / 4 = 25 MHz); legal 1..16
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  synchronous active-low reset
- pix_en  output  1  one-clk pulse; outputs updated to a new pixel this cycle
- hs  output  1  horizontal sync (active low by default)
- vs  output  1  vertical sync (active low by default)
- video_on  output  1  high while (px_x, px_y) is inside the visible area
- px_x  output  10  current horizontal count, 0..H_TOTAL-1
- px_y  output  10  current vertical count, 0..V_TOTAL-1
- frame_start  output  1  one-clk pulse when the counters enter (0,0)

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both must be ≤1024; this is an elaboration-time check.
- Clock divider:
  - div counter 0..CLK_DIV-1, increments every clk and wraps.
  - A tick occurs on the edge where div == CLK_DIV-1.
  - CLK_DIV=1 means a tick on every clk.
- On each tick:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 at V_TOTAL-1 (only on an h wrap).
- All outputs are registered and updated on the same edge as the counters, decoded from the new counter values, so they are always mutually consistent.
- Decodes:
  - px_x = h_cnt; px_y = v_cnt.
  - video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vs asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491. vs changes only on h wrap ticks.
  - pix_en = 1 for exactly the clk following each tick edge, else 0.
  - frame_start = 1 for that same clk when the new counters are (0,0), else 0.
- Reset (rst_n low at a clk edge):
  - div = 0, h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1.
  - hs = 1, vs = 1 (deasserted), video_on = 0, px_x = 0, px_y = 0, pix_en = 0, frame_start = 0.
  - Reset has priority over a tick in the same cycle.
- After reset release:
  - The first tick occurs CLK_DIV clks later.
  - That tick moves the counters to (0,0) and pulses frame_start with pix_en.
- Reset mid-frame aborts the frame immediately; no partial-sync glitch other than the forced deassert.
- Timing: line period = H_TOTAL*CLK_DIV clk (3200); frame = H_TOTAL*V_TOTAL*CLK_DIV clk (1,680,000).
- Outputs hold their value between ticks.

Optional Feature:
- Macro VGA_POS_SYNC_EN.
- Defined: hs and vs are active high; their reset/deasserted value is 0.
- Undefined: active low as above; reset/deasserted value is 1.
- Counter, video_on and pulse behaviour are identical in both builds.

Test Plan:
- Hold rst_n=0 for 5 clk -> hs=1, vs=1, video_on=0, px_x=0, px_y=0, pix_en=0, frame_start=0 throughout.
- Release rst_n; count clks -> at clk 4 after release pix_en=1, frame_start=1, px_x=0, px_y=0, video_on=1; the next pix_en comes 4 clks later with px_x=1.
- Run one line -> hs low for exactly 96 ticks (384 clk), starting at px_x=656; video_on falls at px_x=640; px_x wraps 799->0 with px_y +1.
- Run one frame -> vs low on exactly lines 490 and 491; frame_start recurs after exactly 1,680,000 clk; video_on=0 for all px_y ≥ 480.
- Assert rst_n=0 for 1 clk at px_x=300, px_y=200 -> next cycle matches the reset values; the first tick after release shows (0,0) with frame_start=1.
- Build with VGA_POS_SYNC_EN -> reset hs=vs=0; hs=1 only for px_x 656..751; vs=1 only for px_y 490..491.
